// File: rtl/dut_sweep_ctrl_pkg.sv
// Shared definitions for the dut sweep controller, its MISR and the bench.
package dut_sweep_ctrl_pkg;

  localparam int          IN_W_DEF      = 20;
  localparam int          OUT_W_DEF     = 40;
  localparam logic [39:0] MISR_POLY_DEF = 40'h80_0000_0053;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    FINISH
  } state_t;

endpackage

// File: rtl/dut_sweep_ctrl_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through
// the feedback taps, and XOR in the new response word.
module sweep_misr
  import dut_sweep_ctrl_pkg::*;
#(
  parameter int               OUT_W     = OUT_W_DEF,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] sig
);

  // Signature register: cleared by reset or a new sweep, advanced once per sample.
  always_ff @(posedge clk) begin
    // NOTE: reset sits inside the clocked block and uses <= like every other
    // state update, so it is synchronous and free of ordering races.
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[OUT_W-2:0], 1'b0}
           ^ (sig[OUT_W-1] ? MISR_POLY : '0)
           ^ data;
    end
  end

endmodule

// File: rtl/dut_sweep_ctrl.sv
// Sweeps an inclusive range of vectors through the combinational dut,
// streams each (vector, response) pair out and compacts responses into a MISR.
module dut_sweep_ctrl
  import dut_sweep_ctrl_pkg::*;
#(
  parameter int               IN_W      = IN_W_DEF,
  parameter int               OUT_W     = OUT_W_DEF,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   range_lo,
  input  logic [IN_W-1:0]   range_hi,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IN_W-1:0]   res_vec,
  output logic [OUT_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [OUT_W-1:0]  signature,
  output logic [IN_W:0]     vec_count
);

  state_t          state_q, state_d;
  logic [IN_W-1:0] hi_q;
  logic            accept;     // good start taken in IDLE
  logic            reject;     // start with range_lo > range_hi
  logic            handshake;  // result consumed this cycle
  logic            sample;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (range_lo <= range_hi) begin
            accept  = 1'b1;
            state_d = DRIVE;
          end else begin
            reject  = 1'b1;
            state_d = FINISH;
          end
        end
      end
      DRIVE:  state_d = SAMPLE;
      SAMPLE: state_d = EMIT;
      EMIT: begin
        if (res_ready) begin
          handshake = 1'b1;
          state_d   = (res_vec == hi_q) ? FINISH : DRIVE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sample    = (state_q == SAMPLE);
  assign res_valid = (state_q == EMIT);
  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE) || (state_q == EMIT);
  assign done      = (state_q == FINISH);

  // Datapath: range latch, vector counter, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      dut_in    <= '0;
      res_vec   <= '0;
      res_data  <= '0;
      range_err <= 1'b0;
      vec_count <= '0;
    end else begin
      if (accept) begin
        hi_q      <= range_hi;
        dut_in    <= range_lo;
        vec_count <= '0;
        range_err <= 1'b0;
      end
      if (reject) begin
        range_err <= 1'b1;
        vec_count <= '0;
      end
      if (sample) begin
        res_data  <= dut_out;
        res_vec   <= dut_in;
        vec_count <= vec_count + (IN_W+1)'(1);
      end
      // Stop on equality with hi so the vector never wraps past the top.
      if (handshake && (res_vec != hi_q)) begin
        dut_in <= dut_in + IN_W'(1);
      end
    end
  end

  sweep_misr #(
    .OUT_W     (OUT_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || reject),
    .en   (sample),
    .data (dut_out),
    .sig  (signature)
  );

endmodule

// File: tb/tb_dut_sweep_ctrl.sv
// Directed bench for dut_sweep_ctrl with a stub dut selected by mode.
module tb_dut_sweep_ctrl;
  import dut_sweep_ctrl_pkg::*;

  localparam int IN_W  = IN_W_DEF;
  localparam int OUT_W = OUT_W_DEF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [IN_W-1:0]   range_lo = '0;
  logic [IN_W-1:0]   range_hi = '0;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [IN_W-1:0]   res_vec;
  logic [OUT_W-1:0]  res_data;
  logic              busy;
  logic              done;
  logic              range_err;
  logic [OUT_W-1:0]  signature;
  logic [IN_W:0]     vec_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] mode = 3'd0;

  logic [IN_W-1:0]  got_vec[$];
  logic [OUT_W-1:0] got_data[$];
  int               done_cnt;
  bit               busy_seen;
  bit               valid_seen;
  bit               prev_stall = 1'b0;
  logic [IN_W-1:0]  prev_vec;
  logic [OUT_W-1:0] prev_data;
  logic [IN_W-1:0]  first_dut_in;

  dut_sweep_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .range_lo  (range_lo),
    .range_hi  (range_hi),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_vec   (res_vec),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .signature (signature),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  // Two structurally different but equivalent "netlists" of the dut logic.
  function automatic logic [OUT_W-1:0] dut_orig(input logic [IN_W-1:0] v);
    return {v ^ {v[9:0], v[19:10]}, v + 20'h12345};
  endfunction

  function automatic logic [OUT_W-1:0] dut_opt(input logic [IN_W-1:0] v);
    logic [9:0] x;
    x = v[19:10] ^ v[9:0];
    return {x, x, v - 20'hEDCBB};
  endfunction

  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
    return {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? 40'h80_0000_0053 : 40'h0) ^ d;
  endfunction

  // Stub dut: combinational from dut_in.
  always_comb begin
    dut_out = '0;
    case (mode)
      3'd0: dut_out = 40'h00_0000_0210;
      3'd1: dut_out = {20'h0, dut_in} + 40'h1;
      3'd2: dut_out = (dut_in == 20'hFFFFE) ? 40'h80_0000_0000 : 40'h0;
      3'd3: dut_out = dut_orig(dut_in);
      3'd4: dut_out = dut_opt(dut_in);
      default: dut_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor on the falling edge: record handshakes, pulses and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", res_valid, 1'b1);
        check("stall_vec", res_vec, prev_vec);
        check("stall_data", res_data, prev_data);
      end
      if (res_valid && res_ready) begin
        got_vec.push_back(res_vec);
        got_data.push_back(res_data);
      end
      if (done)      done_cnt++;
      if (busy)      busy_seen = 1'b1;
      if (res_valid) valid_seen = 1'b1;
      prev_stall = res_valid && !res_ready;
      prev_vec   = res_vec;
      prev_data  = res_data;
    end
  end

  // Pulse start, then run until done (bounded), optionally stalling each
  // result for four cycles and injecting a start while busy. Ends one cycle
  // after done so the monitor has seen the pulse.
  task automatic run_sweep(input logic [IN_W-1:0] lo, input logic [IN_W-1:0] hi,
                           input bit stall, input bit inject, input int budget,
                           output int cyc);
    int wait_cnt;
    got_vec.delete();
    got_data.delete();
    done_cnt   = 0;
    busy_seen  = 1'b0;
    valid_seen = 1'b0;
    range_lo   = lo;
    range_hi   = hi;
    start      = 1'b1;
    res_ready  = !stall;
    tick();
    start        = 1'b0;
    first_dut_in = dut_in;
    cyc          = 0;
    wait_cnt     = 0;
    while (!done && cyc < budget) begin
      if (inject && cyc == 6) begin
        range_lo = 20'd100;
        range_hi = 20'd200;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (stall) begin
        if (res_valid && wait_cnt < 4) begin
          res_ready = 1'b0;
          wait_cnt++;
        end else if (res_valid) begin
          res_ready = 1'b1;
          wait_cnt  = 0;
        end else begin
          res_ready = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_reached", done, 1'b1);
    res_ready = 1'b1;
    tick();
  endtask

  int               cyc;
  logic [OUT_W-1:0] exp_sig;
  logic [OUT_W-1:0] sig_orig;

  initial begin
    // Reset state.
    repeat (2) tick();
    rst = 1'b0;
    check("rst_state_busy", busy, 1'b0);
    check("rst_state_valid", res_valid, 1'b0);
    check("rst_state_sig", signature, 40'h0);
    check("rst_state_cnt", vec_count, 21'h0);
    check("rst_state_dut_in", dut_in, 20'h0);

    // Single vector: done in the FINISH cycle, three edges after the start edge.
    mode = 3'd0;
    run_sweep(20'd0, 20'd0, 1'b0, 1'b0, 20, cyc);
    check("single_done_cyc", cyc, 3);
    check("single_n", got_vec.size(), 1);
    check("single_vec", got_vec[0], 20'h0);
    check("single_data", got_data[0], 40'h210);
    check("single_sig", signature, 40'h210);
    check("single_cnt", vec_count, 21'd1);
    check("single_done_pulses", done_cnt, 1);
    check("single_done_low", done, 1'b0);

    // Bad range: done next cycle, never busy, no results.
    run_sweep(20'd10, 20'd3, 1'b0, 1'b0, 10, cyc);
    check("bad_done_cyc", cyc, 0);
    check("bad_err", range_err, 1'b1);
    check("bad_busy", busy_seen, 1'b0);
    check("bad_valid", valid_seen, 1'b0);
    check("bad_sig", signature, 40'h0);
    check("bad_cnt", vec_count, 21'd0);
    check("bad_done_pulses", done_cnt, 1);

    // Two vectors: responses 1 then 2 -> (1<<1)^2 = 0.
    mode = 3'd1;
    run_sweep(20'd0, 20'd1, 1'b0, 1'b0, 20, cyc);
    check("two_err_cleared", range_err, 1'b0);
    check("two_n", got_vec.size(), 2);
    check("two_data0", got_data[0], 40'h1);
    check("two_data1", got_data[1], 40'h2);
    check("two_sig", signature, 40'h0);
    check("two_cnt", vec_count, 21'd2);

    // Backpressure with a start injected mid-sweep (must be ignored).
    run_sweep(20'd5, 20'd7, 1'b1, 1'b1, 60, cyc);
    check("bp_first_dut_in", first_dut_in, 20'd5);
    check("bp_n", got_vec.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("bp_vec", got_vec[i], 20'(5 + i));
      check("bp_data", got_data[i], 40'(6 + i));
    end
    check("bp_cnt", vec_count, 21'd3);
    check("bp_done_pulses", done_cnt, 1);

    // Top of range: feedback taps fire on the second sample.
    // sig1 = 0x80_0000_0000, sig2 = (sig1<<1) ^ POLY ^ 0 = 0x80_0000_0053.
    mode = 3'd2;
    run_sweep(20'hFFFFE, 20'hFFFFF, 1'b0, 1'b0, 20, cyc);
    check("top_last_dut_in", dut_in, 20'hFFFFF);
    check("top_cnt", vec_count, 21'd2);
    check("top_sig", signature, 40'h80_0000_0053);
    repeat (3) tick();
    check("top_sig_stable", signature, 40'h80_0000_0053);

    // Reset during EMIT: everything back to zero, no done pulse.
    done_cnt  = 0;
    res_ready = 1'b0;
    range_lo  = 20'hFFFFE;
    range_hi  = 20'hFFFFF;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (!res_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("rst_reached_emit", res_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_dut_in", dut_in, 20'h0);
    check("mid_rst_vec", res_vec, 20'h0);
    check("mid_rst_data", res_data, 40'h0);
    check("mid_rst_sig", signature, 40'h0);
    check("mid_rst_cnt", vec_count, 21'h0);
    res_ready = 1'b1;
    repeat (5) tick();
    check("mid_rst_no_done", done_cnt, 0);

    // Real dut hookup: original and optimised netlists give one signature.
    exp_sig = '0;
    for (int v = 0; v < 4096; v++) exp_sig = misr_step(exp_sig, dut_orig(20'(v)));
    mode = 3'd3;
    run_sweep(20'h0, 20'hFFF, 1'b0, 1'b0, 4096 * 3 + 20, cyc);
    sig_orig = signature;
    check("real_orig_sig", signature, exp_sig);
    check("real_orig_cnt", vec_count, 21'd4096);
    check("real_orig_n", got_vec.size(), 4096);
    mode = 3'd4;
    run_sweep(20'h0, 20'hFFF, 1'b0, 1'b0, 4096 * 3 + 20, cyc);
    check("real_opt_sig", signature, sig_orig);
    check("real_opt_cnt", vec_count, 21'd4096);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
